// File: rtl/pkt_pkg.sv
// Shared packet definitions: type encoding, per-type word counts and the
// per-type field layout used by the unpacker (and by the reward packer).
package pkt_pkg;

    localparam int RX_TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        PT_HB      = 3'd0,
        PT_CHE     = 3'd1,
        PT_INV     = 3'd2,
        PT_MR      = 3'd3,
        PT_CHT     = 3'd4,
        PT_DATA    = 3'd5,
        PT_SOS     = 3'd6,
        PT_INVALID = 3'd7
    } pkt_type_e;

    typedef enum logic [3:0] {
        FS_NONE         = 4'd0,
        FS_SOURCE_ID    = 4'd1,
        FS_SOURCE_HOPS  = 4'd2,
        FS_QVALUE       = 4'd3,
        FS_ENERGY_LEFT  = 4'd4,
        FS_HOPS_FROM_CH = 4'd5,
        FS_CHOSEN_CH    = 4'd6,
        FS_DEST_ID      = 4'd7,
        FS_TIMESLOT     = 4'd8,
        FS_PAYLOAD      = 4'd9
    } field_sel_e;

    // Total words in a frame, header included.
    function automatic logic [3:0] pkt_words(input pkt_type_e t);
        logic [3:0] n;
        case (t)
            PT_HB, PT_CHE:   n = 4'd3;
            PT_INV:          n = 4'd4;
            PT_MR:           n = 4'd7;
            PT_CHT:          n = 4'd5;
            PT_DATA, PT_SOS: n = 4'd9;
            default:         n = 4'd1;
        endcase
        return n;
    endfunction

    // Field carried by word 'idx' (1 = first word after the header).
    function automatic field_sel_e field_at(input pkt_type_e t, input logic [3:0] idx);
        field_sel_e f;
        f = FS_NONE;
        case (t)
            PT_HB: begin
                case (idx)
                    4'd1:    f = FS_SOURCE_ID;
                    4'd2:    f = FS_SOURCE_HOPS;
                    default: f = FS_NONE;
                endcase
            end
            PT_CHE: begin
                case (idx)
                    4'd1:    f = FS_SOURCE_ID;
                    4'd2:    f = FS_DEST_ID;
                    default: f = FS_NONE;
                endcase
            end
            PT_INV: begin
                case (idx)
                    4'd1:    f = FS_SOURCE_ID;
                    4'd2:    f = FS_QVALUE;
                    4'd3:    f = FS_HOPS_FROM_CH;
                    default: f = FS_NONE;
                endcase
            end
            PT_MR: begin
                case (idx)
                    4'd1:    f = FS_SOURCE_ID;
                    4'd2:    f = FS_SOURCE_HOPS;
                    4'd3:    f = FS_QVALUE;
                    4'd4:    f = FS_ENERGY_LEFT;
                    4'd5:    f = FS_DEST_ID;
                    4'd6:    f = FS_HOPS_FROM_CH;
                    default: f = FS_NONE;
                endcase
            end
            PT_CHT: begin
                case (idx)
                    4'd1:    f = FS_SOURCE_ID;
                    4'd2:    f = FS_QVALUE;
                    4'd3:    f = FS_DEST_ID;
                    4'd4:    f = FS_TIMESLOT;
                    default: f = FS_NONE;
                endcase
            end
            PT_DATA, PT_SOS: begin
                case (idx)
                    4'd1:    f = FS_SOURCE_ID;
                    4'd2:    f = FS_SOURCE_HOPS;
                    4'd3:    f = FS_QVALUE;
                    4'd4:    f = FS_ENERGY_LEFT;
                    4'd5:    f = FS_HOPS_FROM_CH;
                    4'd6:    f = FS_CHOSEN_CH;
                    4'd7:    f = FS_DEST_ID;
                    4'd8:    f = FS_PAYLOAD;
                    default: f = FS_NONE;
                endcase
            end
            default: f = FS_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pkt_unpacker_if.sv
// Bus between the radio word stream / packet consumer and the unpacker.
// Handshakes: a word moves on a rising edge with rx_valid && rx_ready; a
// presented packet (pkt_valid) is released on the edge where pkt_ack is high.
interface pkt_unpacker_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  rx_valid;
    logic                  rx_sof;
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_ready;

    logic                  pkt_ack;
    logic                  pkt_valid;
    logic                  pkt_err;

    logic [2:0]            fPacketType;
    logic [WORD_WIDTH-1:0] fSourceID;
    logic [WORD_WIDTH-1:0] fSourceHops;
    logic [WORD_WIDTH-1:0] fQValue;
    logic [WORD_WIDTH-1:0] fEnergyLeft;
    logic [WORD_WIDTH-1:0] fHopsFromCH;
    logic [WORD_WIDTH-1:0] fChosenCH;
    logic [WORD_WIDTH-1:0] fDestinationID;
    logic [WORD_WIDTH-1:0] fTimeslot;
    logic [WORD_WIDTH-1:0] fPayload;
    logic                  iAmDestination;

    // FSM state for observation only
    logic [1:0]            fsm_state;

    modport master (
        output rx_valid, rx_sof, rx_data, pkt_ack,
        input  rx_ready, pkt_valid, pkt_err,
        input  fPacketType, fSourceID, fSourceHops, fQValue, fEnergyLeft,
        input  fHopsFromCH, fChosenCH, fDestinationID, fTimeslot, fPayload,
        input  iAmDestination, fsm_state
    );

    modport slave (
        input  rx_valid, rx_sof, rx_data, pkt_ack,
        output rx_ready, pkt_valid, pkt_err,
        output fPacketType, fSourceID, fSourceHops, fQValue, fEnergyLeft,
        output fHopsFromCH, fChosenCH, fDestinationID, fTimeslot, fPayload,
        output iAmDestination, fsm_state
    );
endinterface

// File: rtl/pkt_unpacker.sv
// Word-serial packet receiver: validates the header type, scatters the
// following words into per-field registers and holds the packet until acked.
module pkt_unpacker
    import pkt_pkg::*;
#(
    parameter int                    WORD_WIDTH = 16,
    parameter int                    RX_TIMEOUT = RX_TIMEOUT_DEFAULT,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID   = {WORD_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    pkt_unpacker_if.slave         bus
);

    localparam logic [1:0] s_idle   = 2'd0;
    localparam logic [1:0] s_fields = 2'd1;
    localparam logic [1:0] s_hold   = 2'd2;

    localparam logic [WORD_WIDTH-1:0] TIMER_LOAD = WORD_WIDTH'(RX_TIMEOUT);

    logic [1:0]            state;
    logic [3:0]            word_idx;
    logic [WORD_WIDTH-1:0] timer;
    pkt_type_e             ptype;
    logic                  err_q;

    logic [WORD_WIDTH-1:0] src_id, src_hops, q_value, energy_left;
    logic [WORD_WIDTH-1:0] hops_from_ch, chosen_ch, dest_id, timeslot, payload;
    logic                  i_am_dest;

    logic                  rx_ready;
    logic                  accept;
    logic                  is_hdr;
    logic                  hdr_valid;
    logic                  new_frame;
    logic                  last_word;
    pkt_type_e             hdr_type;
    field_sel_e            wr_sel;

    always_comb begin
        rx_ready  = (state != s_hold);
        accept    = bus.rx_valid && rx_ready;
        hdr_type  = pkt_type_e'(bus.rx_data[2:0]);
        is_hdr    = accept && bus.rx_sof;
        hdr_valid = (hdr_type != PT_INVALID);
        new_frame = is_hdr && hdr_valid;
        last_word = (word_idx == (pkt_words(ptype) - 4'd1));
        wr_sel    = FS_NONE;
        if ((state == s_fields) && accept && !bus.rx_sof) begin
            wr_sel = field_at(ptype, word_idx);
        end
    end

    // Control path: state, word index, inter-word timer and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= s_idle;
            word_idx <= 4'd0;
            timer    <= '0;
            ptype    <= PT_INVALID;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                s_idle: begin
                    if (new_frame) begin
                        ptype    <= hdr_type;
                        word_idx <= 4'd1;
                        timer    <= TIMER_LOAD;
                        state    <= s_fields;
                    end else if (is_hdr) begin
                        err_q <= 1'b1;
                    end
                end
                s_fields: begin
                    if (is_hdr) begin
                        // A header mid-frame always aborts; it may also start a new frame.
                        err_q <= 1'b1;
                        if (hdr_valid) begin
                            ptype    <= hdr_type;
                            word_idx <= 4'd1;
                            timer    <= TIMER_LOAD;
                        end else begin
                            state <= s_idle;
                        end
                    end else if (accept) begin
                        timer <= TIMER_LOAD;
                        if (last_word) begin
                            state <= s_hold;
                        end else begin
                            word_idx <= word_idx + 4'd1;
                        end
                    end else if (timer <= {{(WORD_WIDTH-1){1'b0}}, 1'b1}) begin
                        timer <= '0;
                        err_q <= 1'b1;
                        state <= s_idle;
                    end else begin
                        timer <= timer - {{(WORD_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                s_hold: begin
                    if (bus.pkt_ack) begin
                        state <= s_idle;
                    end
                end
                default: state <= s_idle;
            endcase
        end
    end

    // Field register bank: cleared on every accepted valid header.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_id       <= '0;
            src_hops     <= '0;
            q_value      <= '0;
            energy_left  <= '0;
            hops_from_ch <= '0;
            chosen_ch    <= '0;
            dest_id      <= '0;
            timeslot     <= '0;
            payload      <= '0;
            i_am_dest    <= 1'b0;
        end else if (new_frame) begin
            src_id       <= '0;
            src_hops     <= '0;
            q_value      <= '0;
            energy_left  <= '0;
            hops_from_ch <= '0;
            chosen_ch    <= '0;
            dest_id      <= '0;
            timeslot     <= '0;
            payload      <= '0;
            i_am_dest    <= 1'b0;
        end else begin
            case (wr_sel)
                FS_SOURCE_ID:    src_id       <= bus.rx_data;
                FS_SOURCE_HOPS:  src_hops     <= bus.rx_data;
                FS_QVALUE:       q_value      <= bus.rx_data;
                FS_ENERGY_LEFT:  energy_left  <= bus.rx_data;
                FS_HOPS_FROM_CH: hops_from_ch <= bus.rx_data;
                FS_CHOSEN_CH:    chosen_ch    <= bus.rx_data;
                FS_DEST_ID: begin
                    dest_id   <= bus.rx_data;
                    i_am_dest <= (bus.rx_data == myNodeID) || (bus.rx_data == BCAST_ID);
                end
                FS_TIMESLOT:     timeslot     <= bus.rx_data;
                FS_PAYLOAD:      payload      <= bus.rx_data;
                default: ;
            endcase
        end
    end

    assign bus.rx_ready       = rx_ready;
    assign bus.pkt_valid      = (state == s_hold);
    assign bus.pkt_err        = err_q;
    assign bus.fPacketType    = ptype;
    assign bus.fSourceID      = src_id;
    assign bus.fSourceHops    = src_hops;
    assign bus.fQValue        = q_value;
    assign bus.fEnergyLeft    = energy_left;
    assign bus.fHopsFromCH    = hops_from_ch;
    assign bus.fChosenCH      = chosen_ch;
    assign bus.fDestinationID = dest_id;
    assign bus.fTimeslot      = timeslot;
    assign bus.fPayload       = payload;
    assign bus.iAmDestination = i_am_dest;
    assign bus.fsm_state      = state;

endmodule

// File: tb/tb_pkt_unpacker.sv
// Self-checking bench for pkt_unpacker: directed scenarios plus random frames
// compared against a layout-string reference model.
module tb_pkt_unpacker;

  localparam int W   = 16;
  localparam int TMO = 16;

  typedef struct packed {
    logic [2:0]   ptype;
    logic [W-1:0] src;
    logic [W-1:0] hops;
    logic [W-1:0] q;
    logic [W-1:0] energy;
    logic [W-1:0] hfc;
    logic [W-1:0] chosen;
    logic [W-1:0] dst;
    logic [W-1:0] ts;
    logic [W-1:0] payload;
    logic         iam;
  } pk_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] my_id;

  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  int   err_long = 0;
  logic err_prev = 1'b0;

  pk_t          exp_q[$];
  logic [W-1:0] frm[$];

  pkt_unpacker_if #(.WORD_WIDTH(W)) bus ();

  pkt_unpacker #(.WORD_WIDTH(W), .RX_TIMEOUT(TMO), .BCAST_ID(16'hFFFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .myNodeID (my_id),
    .bus      (bus)
  );

  // ---------------- clock / reset / monitors ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pkt_err) err_cnt++;
      if (bus.pkt_err && err_prev) err_long++;
      err_prev = bus.pkt_err;
    end else begin
      err_prev = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // One letter per word after the header:
  // S src, H hops, Q qvalue, E energy, F hops-from-CH, C chosen CH, D dest, T timeslot, P payload
  function automatic string layout(input int t);
    case (t)
      0:       return "SH";
      1:       return "SD";
      2:       return "SQF";
      3:       return "SHQEDF";
      4:       return "SQDT";
      default: return "SHQEFCDP";
    endcase
  endfunction

  function automatic pk_t model(input int t, input logic [W-1:0] me);
    pk_t   e;
    string s;
    e = '0;
    e.ptype = t[2:0];
    s = layout(t);
    for (int i = 0; i < s.len() && i + 1 < frm.size(); i++) begin
      case (s[i])
        "S": e.src     = frm[i+1];
        "H": e.hops    = frm[i+1];
        "Q": e.q       = frm[i+1];
        "E": e.energy  = frm[i+1];
        "F": e.hfc     = frm[i+1];
        "C": e.chosen  = frm[i+1];
        "T": e.ts      = frm[i+1];
        "P": e.payload = frm[i+1];
        "D": begin
          e.dst = frm[i+1];
          e.iam = (frm[i+1] == me) || (frm[i+1] == 16'hFFFF);
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic pk_t reset_pkt();
    pk_t e;
    e = '0;
    e.ptype = 3'b111;
    return e;
  endfunction

  function automatic pk_t dut_pkt();
    pk_t g;
    g.ptype   = bus.fPacketType;
    g.src     = bus.fSourceID;
    g.hops    = bus.fSourceHops;
    g.q       = bus.fQValue;
    g.energy  = bus.fEnergyLeft;
    g.hfc     = bus.fHopsFromCH;
    g.chosen  = bus.fChosenCH;
    g.dst     = bus.fDestinationID;
    g.ts      = bus.fTimeslot;
    g.payload = bus.fPayload;
    g.iam     = bus.iAmDestination;
    return g;
  endfunction

  function automatic void build_frame(input int t, input logic [W-1:0] dst);
    string        s;
    logic [W-1:0] v;
    frm.delete();
    frm.push_back({13'($urandom), 3'(t)});
    s = layout(t);
    for (int i = 0; i < s.len(); i++) begin
      v = 16'($urandom);
      if (s[i] == "D") v = dst;
      frm.push_back(v);
    end
  endfunction

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send_word(input logic sof, input logic [W-1:0] d);
    int n;
    bus.rx_valid = 1'b1;
    bus.rx_sof   = sof;
    bus.rx_data  = d;
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_wait got=0 exp=1 within 50 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
  endtask

  task automatic send_words(input int first, input int last, input int gap_max);
    int g;
    for (int i = first; i <= last; i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) @(negedge clk);
      send_word(i == 0, frm[i]);
    end
  endtask

  task automatic do_ack();
    bus.pkt_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pkt_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (bus.rx_ready !== 1'b1 || bus.pkt_valid !== 1'b0 || bus.pkt_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b valid=%b err=%b exp 1 0 0", bus.rx_ready, bus.pkt_valid, bus.pkt_err);
    end
    checks++;
    if (dut_pkt() !== reset_pkt()) begin
      errors++;
      $display("FAIL reset_fields got=%h exp=%h", dut_pkt(), reset_pkt());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // ack with nothing presented must do nothing
    do_ack();
    checks++;
    if (bus.pkt_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ack got valid=%b ready=%b exp 0 1", bus.pkt_valid, bus.rx_ready);
    end
  endtask

  task automatic test_hb();
    pk_t e;
    my_id = 16'd5;
    frm.delete();
    frm.push_back(16'h0000);
    frm.push_back(16'h0007);
    frm.push_back(16'h0002);
    e = model(0, my_id);
    send_words(0, 1, 0);
    checks++;
    if (bus.pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL hb_early_valid got=%b exp=0", bus.pkt_valid);
    end
    send_word(1'b0, frm[2]);
    checks++;
    if (bus.pkt_valid !== 1'b1 || bus.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL hb_valid got valid=%b ready=%b exp 1 0", bus.pkt_valid, bus.rx_ready);
    end
    checks++;
    if (dut_pkt() !== e) begin
      errors++;
      $display("FAIL hb_fields got=%h exp=%h", dut_pkt(), e);
    end
    checks++;
    if (bus.fSourceID !== 16'd7 || bus.fSourceHops !== 16'd2 || bus.iAmDestination !== 1'b0) begin
      errors++;
      $display("FAIL hb_values got src=%h hops=%h iam=%b exp 0007 0002 0", bus.fSourceID, bus.fSourceHops, bus.iAmDestination);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pkt_valid !== 1'b1 || dut_pkt() !== e) begin
      errors++;
      $display("FAIL hb_hold got valid=%b fields=%h exp 1 %h", bus.pkt_valid, dut_pkt(), e);
    end
    do_ack();
    checks++;
    if (bus.pkt_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL hb_ack got valid=%b ready=%b exp 0 1", bus.pkt_valid, bus.rx_ready);
    end
  endtask

  task automatic test_data();
    logic [W-1:0] dsts[3];
    logic         iams[3];
    pk_t          e;
    dsts[0] = 16'd5;    iams[0] = 1'b1;
    dsts[1] = 16'hFFFF; iams[1] = 1'b1;
    dsts[2] = 16'd6;    iams[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      build_frame(5, dsts[k]);
      frm[8] = 16'hBEEF;
      e = model(5, my_id);
      send_words(0, 8, 0);
      checks++;
      if (bus.pkt_valid !== 1'b1 || dut_pkt() !== e) begin
        errors++;
        $display("FAIL data_fields[%0d] got valid=%b fields=%h exp 1 %h", k, bus.pkt_valid, dut_pkt(), e);
      end
      checks++;
      if (bus.iAmDestination !== iams[k] || bus.fPayload !== 16'hBEEF || bus.fPacketType !== 3'b101) begin
        errors++;
        $display("FAIL data_dest[%0d] got iam=%b payload=%h type=%b exp %b beef 101", k, bus.iAmDestination, bus.fPayload, bus.fPacketType, iams[k]);
      end
      do_ack();
    end
  endtask

  task automatic test_invalid_type();
    pk_t prev;
    int  e0;
    int  bad_valid;
    prev = model(5, my_id);   // frm still holds the last data frame
    e0 = err_cnt;
    bad_valid = 0;
    send_word(1'b1, 16'h0007);
    if (bus.pkt_valid) bad_valid++;
    send_word(1'b0, 16'h1234);
    if (bus.pkt_valid) bad_valid++;
    send_word(1'b0, 16'h5678);
    if (bus.pkt_valid) bad_valid++;
    repeat (2) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL invalid_err got=%0d pulses exp=1", err_cnt - e0);
    end
    checks++;
    if (bad_valid !== 0 || bus.pkt_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL invalid_valid got valid_cycles=%0d ready=%b exp 0 1", bad_valid, bus.rx_ready);
    end
    checks++;
    if (dut_pkt() !== prev) begin
      errors++;
      $display("FAIL invalid_fields got=%h exp=%h", dut_pkt(), prev);
    end
  endtask

  task automatic test_timeout();
    pk_t e;
    int  e0;
    int  cyc;
    build_frame(2, 16'h0);
    e0 = err_cnt;
    send_words(0, 1, 0);
    cyc = 0;
    while (!bus.pkt_err && cyc < 3 * TMO) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== TMO) begin
      errors++;
      $display("FAIL timeout_cycles got=%0d exp=%0d", cyc, TMO);
    end
    @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 1 || bus.pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err got pulses=%0d valid=%b exp 1 0", err_cnt - e0, bus.pkt_valid);
    end
    build_frame(3, my_id);
    e = model(3, my_id);
    send_words(0, 6, 1);
    checks++;
    if (bus.pkt_valid !== 1'b1 || dut_pkt() !== e) begin
      errors++;
      $display("FAIL timeout_mr got valid=%b fields=%h exp 1 %h", bus.pkt_valid, dut_pkt(), e);
    end
    do_ack();
  endtask

  task automatic test_abort();
    pk_t e;
    int  e0;
    build_frame(3, 16'h0042);
    send_words(0, 4, 0);      // header + src, hops, qvalue, energy
    build_frame(4, my_id);
    e = model(4, my_id);
    e0 = err_cnt;
    send_words(0, 4, 0);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL abort_err got=%0d pulses exp=1", err_cnt - e0);
    end
    checks++;
    if (bus.pkt_valid !== 1'b1 || dut_pkt() !== e) begin
      errors++;
      $display("FAIL abort_cht got valid=%b fields=%h exp 1 %h", bus.pkt_valid, dut_pkt(), e);
    end
    checks++;
    if (bus.fEnergyLeft !== 16'h0 || bus.fTimeslot !== frm[4]) begin
      errors++;
      $display("FAIL abort_values got energy=%h ts=%h exp 0000 %h", bus.fEnergyLeft, bus.fTimeslot, frm[4]);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int           t;
    logic [W-1:0] d;
    pk_t          e;
    for (int n = 0; n < 25; n++) begin
      t = $urandom_range(0, 6);
      case ($urandom_range(0, 2))
        0:       d = my_id;
        1:       d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      build_frame(t, d);
      exp_q.push_back(model(t, my_id));
      send_words(0, frm.size() - 1, (n % 3 == 0) ? 0 : 3);
      e = exp_q.pop_front();
      checks++;
      if (bus.pkt_valid !== 1'b1 || dut_pkt() !== e) begin
        errors++;
        $display("FAIL rand_frame[%0d] type=%0d got valid=%b fields=%h exp 1 %h", n, t, bus.pkt_valid, dut_pkt(), e);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_ack();
      checks++;
      if (bus.pkt_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_ack[%0d] got valid=%b ready=%b exp 0 1", n, bus.pkt_valid, bus.rx_ready);
      end
    end
  endtask

  task automatic test_rst_hold();
    build_frame(1, my_id);
    send_words(0, 2, 0);
    checks++;
    if (bus.pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_valid got=%b exp=1", bus.pkt_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.pkt_valid !== 1'b0 || bus.rx_ready !== 1'b1 || bus.pkt_err !== 1'b0 || dut_pkt() !== reset_pkt()) begin
      errors++;
      $display("FAIL rst_hold got valid=%b ready=%b err=%b fields=%h exp 0 1 0 %h",
               bus.pkt_valid, bus.rx_ready, bus.pkt_err, dut_pkt(), reset_pkt());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst          = 1'b1;
    my_id        = 16'd5;
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_data  = '0;
    bus.pkt_ack  = 1'b0;
    @(negedge clk);
    test_reset();
    test_hb();
    test_data();
    test_invalid_type();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_rst_hold();
    checks++;
    if (err_long !== 0) begin
      errors++;
      $display("FAIL err_pulse_width got=%0d multi-cycle pulses exp=0", err_long);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
